// File: rtl/cpu_pirq_arbiter_pkg.sv
// rtl/cpu_pirq_arbiter_pkg.sv - shared types and constants for the PIRQ arbiter
// The DEFER state encoding exists only when PIRQ_DEFER_EN is defined.
package cpu_pirq_arbiter_pkg;

   localparam logic [15:0] PIRQ_VECTOR_DEF = 16'o000240;
   localparam int          PIR_REQ_MSB     = 15;
   localparam int          PIR_REQ_LSB     = 9;
   localparam int          PIR_REQ_W       = PIR_REQ_MSB - PIR_REQ_LSB + 1;

`ifdef PIRQ_DEFER_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ACK   = 2'd2,
      ST_DEFER = 2'd3
   } pirq_state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ACK   = 2'd2
   } pirq_state_t;
`endif

endpackage

// File: rtl/pirq_prio_enc.sv
// rtl/pirq_prio_enc.sv - combinational 7-to-3 priority encoder for PIRQ levels
// req[6] is level 7, req[0] is level 1; no request encodes as level 0.
module pirq_prio_enc (
   input  logic [6:0] req,
   output logic [2:0] lvl
);

   always_comb begin
      lvl = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (req[i]) lvl = 3'(i + 1);
      end
   end

endmodule

// File: rtl/cpu_pirq_arbiter.sv
// rtl/cpu_pirq_arbiter.sv - program-interrupt-request arbiter feeding the CPU trap sequencer
// Optional PIRQ_DEFER_EN holds off re-requests until one instruction fetch after acknowledge.
module cpu_pirq_arbiter
   import cpu_pirq_arbiter_pkg::*;
#(
   parameter logic [15:0] VECTOR = PIRQ_VECTOR_DEF
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n,
   input  logic [15:0] pir_in,
   input  logic [2:0]  psw_pri,
   input  logic        iack_i,
   input  logic        ifetch_i,
   output logic        irq_o,
   output logic [2:0]  ipl_o,
   output logic [15:0] ivec_o,
   output logic        busy_o
);

   pirq_state_t          state_q, state_d;
   logic [PIR_REQ_W-1:0] pend_q;
   logic [2:0]           pri_q;
   logic [2:0]           lvl;
   logic [2:0]           ipl_d;
   logic                 elig;

   logic unused_pir_low;
   assign unused_pir_low = ^pir_in[PIR_REQ_LSB-1:0];
`ifndef PIRQ_DEFER_EN
   logic unused_ifetch;
   assign unused_ifetch = ifetch_i;
`endif

   pirq_prio_enc u_prio_enc (
      .req (pend_q),
      .lvl (lvl)
   );

   assign elig = (lvl > pri_q);

   always_comb begin
      state_d = state_q;
      ipl_d   = ipl_o;
      case (state_q)
         ST_IDLE: begin
            if (elig) begin
               state_d = ST_REQ;
               ipl_d   = lvl;
            end
         end
         ST_REQ: begin
            // Acknowledge wins over withdraw/preempt so ipl_o stays put while iack_i is high.
            if (iack_i)          state_d = ST_ACK;
            else if (!elig)      state_d = ST_IDLE;
            else if (lvl != ipl_o) ipl_d = lvl;
         end
         ST_ACK: begin
            if (!iack_i) begin
`ifdef PIRQ_DEFER_EN
               state_d = ST_DEFER;
`else
               state_d = ST_IDLE;
`endif
            end
         end
`ifdef PIRQ_DEFER_EN
         ST_DEFER: begin
            if (ifetch_i) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are true registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         pri_q   <= 3'd7;
         ipl_o   <= 3'd0;
         irq_o   <= 1'b0;
         ivec_o  <= 16'd0;
         busy_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pir_in[PIR_REQ_MSB:PIR_REQ_LSB];
         pri_q   <= psw_pri;
         ipl_o   <= ipl_d;
         irq_o   <= (state_d == ST_REQ);
         ivec_o  <= ((state_d == ST_REQ) || (state_d == ST_ACK)) ? VECTOR : 16'd0;
         busy_o  <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_cpu_pirq_arbiter.sv
// tb/tb_cpu_pirq_arbiter.sv - directed self-checking bench for cpu_pirq_arbiter
module tb_cpu_pirq_arbiter;

   logic        clk;
   logic        rst_n;
   logic [15:0] pir_in;
   logic [2:0]  psw_pri;
   logic        iack;
   logic        ifetch;
   logic        irq;
   logic [2:0]  ipl;
   logic [15:0] ivec;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   cpu_pirq_arbiter dut (
      .wb_clk_i (clk),
      .wb_rst_n (rst_n),
      .pir_in   (pir_in),
      .psw_pri  (psw_pri),
      .iack_i   (iack),
      .ifetch_i (ifetch),
      .irq_o    (irq),
      .ipl_o    (ipl),
      .ivec_o   (ivec),
      .busy_o   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic leave_ack();
      iack = 1'b0;
      tick();
`ifdef PIRQ_DEFER_EN
      ifetch = 1'b1;
      tick();
      ifetch = 1'b0;
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pir_in = 16'd0; psw_pri = 3'd0; iack = 1'b0; ifetch = 1'b0;
      tick(2);
      checks++;
      if (irq !== 1'b0 || ipl !== 3'd0 || ivec !== 16'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset: irq=%b ipl=%0d ivec=%o busy=%b want 0/0/0/0", irq, ipl, ivec, busy);
      end
      rst_n = 1'b1;
      tick(3);
      checks++;
      if (irq !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: irq=%b busy=%b want 0/0", irq, busy);
      end
   endtask

   task automatic test_basic();
      psw_pri = 3'd0;
      pir_in  = 16'o040000;
      tick();
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL basic_latency1: irq=%b want 0", irq);
      end
      tick();
      checks++;
      if (irq !== 1'b1 || ipl !== 3'd6 || ivec !== 16'o000240 || busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_req: irq=%b ipl=%0d ivec=%o busy=%b want 1/6/240/1", irq, ipl, ivec, busy);
      end
      iack = 1'b1;
      tick();
      checks++;
      if (irq !== 1'b0 || ipl !== 3'd6 || ivec !== 16'o000240 || busy !== 1'b1) begin
         failures++;
         $display("FAIL basic_ack: irq=%b ipl=%0d ivec=%o busy=%b want 0/6/240/1", irq, ipl, ivec, busy);
      end
      tick(2);
      iack = 1'b0;
      tick();
`ifdef PIRQ_DEFER_EN
      checks++;
      if (irq !== 1'b0 || busy !== 1'b1 || ivec !== 16'd0) begin
         failures++;
         $display("FAIL defer_hold: irq=%b busy=%b ivec=%o want 0/1/0", irq, busy, ivec);
      end
      tick(3);
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL defer_wait: irq=%b want 0", irq);
      end
      ifetch = 1'b1;
      tick();
      ifetch = 1'b0;
`endif
      checks++;
      if (irq !== 1'b0 || busy !== 1'b0 || ivec !== 16'd0) begin
         failures++;
         $display("FAIL basic_idle: irq=%b busy=%b ivec=%o want 0/0/0", irq, busy, ivec);
      end
      tick();
      checks++;
      if (irq !== 1'b1 || ipl !== 3'd6) begin
         failures++;
         $display("FAIL basic_rereq: irq=%b ipl=%0d want 1/6", irq, ipl);
      end
      pir_in = 16'd0;
      tick(2);
      checks++;
      if (irq !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_withdraw: irq=%b busy=%b want 0/0", irq, busy);
      end
   endtask

   task automatic test_mask();
      int seen = 0;
      psw_pri = 3'd5;
      pir_in  = 16'o020000;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (irq !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL mask_equal: irq high in %0d cycles want 0", seen);
      end
      psw_pri = 3'd4;
      tick(2);
      checks++;
      if (irq !== 1'b1 || ipl !== 3'd5) begin
         failures++;
         $display("FAIL mask_lowered: irq=%b ipl=%0d want 1/5", irq, ipl);
      end
      psw_pri = 3'd6;
      tick(2);
      checks++;
      if (irq !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mask_raise_withdraw: irq=%b busy=%b want 0/0", irq, busy);
      end
      pir_in  = 16'd0;
      psw_pri = 3'd0;
      tick(2);
   endtask

   task automatic test_preempt();
      pir_in = 16'o002000;
      tick(2);
      checks++;
      if (irq !== 1'b1 || ipl !== 3'd2) begin
         failures++;
         $display("FAIL preempt_low: irq=%b ipl=%0d want 1/2", irq, ipl);
      end
      pir_in = 16'o102000;
      tick(2);
      checks++;
      if (irq !== 1'b1 || ipl !== 3'd7) begin
         failures++;
         $display("FAIL preempt_high: irq=%b ipl=%0d want 1/7", irq, ipl);
      end
      iack = 1'b1;
      tick();
      checks++;
      if (irq !== 1'b0 || ipl !== 3'd7 || busy !== 1'b1) begin
         failures++;
         $display("FAIL preempt_ack: irq=%b ipl=%0d busy=%b want 0/7/1", irq, ipl, busy);
      end
      pir_in = 16'd0;
      leave_ack();
      tick();
      checks++;
      if (busy !== 1'b0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL preempt_idle: busy=%b irq=%b want 0/0", busy, irq);
      end
   endtask

   task automatic test_race();
      pir_in = 16'o040000;
      tick(2);
      pir_in = 16'd0;
      iack   = 1'b1;
      tick();
      checks++;
      if (irq !== 1'b0 || busy !== 1'b1 || ipl !== 3'd6 || ivec !== 16'o000240) begin
         failures++;
         $display("FAIL race_ack_wins: irq=%b busy=%b ipl=%0d ivec=%o want 0/1/6/240", irq, busy, ipl, ivec);
      end
      leave_ack();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL race_ack_idle: busy=%b want 0", busy);
      end
      pir_in = 16'o040000;
      tick(2);
      pir_in = 16'd0;
      tick(2);
      iack = 1'b1;
      tick();
      checks++;
      if (irq !== 1'b0 || busy !== 1'b0 || ivec !== 16'd0) begin
         failures++;
         $display("FAIL race_stale_iack: irq=%b busy=%b ivec=%o want 0/0/0", irq, busy, ivec);
      end
      iack = 1'b0;
      tick();
   endtask

   task automatic test_mid_reset();
      pir_in = 16'o004000;
      tick(2);
      checks++;
      if (irq !== 1'b1 || ipl !== 3'd3) begin
         failures++;
         $display("FAIL midrst_req: irq=%b ipl=%0d want 1/3", irq, ipl);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (irq !== 1'b0 || ipl !== 3'd0 || ivec !== 16'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midrst_async: irq=%b ipl=%0d ivec=%o busy=%b want 0/0/0/0", irq, ipl, ivec, busy);
      end
      pir_in = 16'd0;
      tick();
      rst_n = 1'b1;
      tick(2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mask();
      test_preempt();
      test_race();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
